// File: rtl/conv_pkg.sv
// conv_pkg: constants and types shared by the convolution engine and its
// layer-memory responder.
//   DATA_W        word width (signed 4.16 fixed point)
//   L0_AW/L1_AW   address widths of the 64x64 and 32x32 feature maps
//   SEL_L0/SEL_L1 csel codes that select each bank
//   rd_state_e    states of the layer-1 readout FSM
package conv_pkg;

  localparam int DATA_W = 20;
  localparam int L0_AW  = 12;
  localparam int L1_AW  = 10;

  localparam logic [2:0] SEL_L0 = 3'd1;
  localparam logic [2:0] SEL_L1 = 3'd3;

  // Address of the final layer-1 word; tags out_last.
  localparam logic [L1_AW-1:0] L1_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/layer_mem_ctrl_if.sv
// layer_mem_ctrl_if: bundles the engine's layer-memory bus and the host
// readout stream.
//   engine bus : csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, cdata_rd
//   host stream: out_valid, out_ready, out_addr, out_data, out_last
// Modports: master = engine + host side, slave = layer_mem_ctrl.
interface layer_mem_ctrl_if;
  import conv_pkg::*;

  logic [2:0]        csel;
  logic              cwr;
  logic [L0_AW-1:0]  caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              crd;
  logic [L0_AW-1:0]  caddr_rd;
  logic [DATA_W-1:0] cdata_rd;

  logic              out_valid;
  logic              out_ready;
  logic [L1_AW-1:0]  out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, out_ready,
    input  cdata_rd, out_valid, out_addr, out_data, out_last
  );

  modport slave (
    input  csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, out_ready,
    output cdata_rd, out_valid, out_addr, out_data, out_last
  );

endinterface

// File: rtl/layer_bank.sv
// layer_bank: one feature-map array with a synchronous write port and NRD
// asynchronous read ports.
//   clk          write clock
//   we/waddr/wdata  write port, stored on the rising edge
//   raddr[i]/rdata[i]  combinational read ports; a same-cycle write is
//                      visible only after the edge (read-old behaviour)
module layer_bank #(
  parameter int AW     = 10,
  parameter int DATA_W = 20,
  parameter int NRD    = 1
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [NRD-1:0][AW-1:0]       raddr,
  output logic [NRD-1:0][DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // NOTE: the array has no reset on purpose; feature maps must survive a
  // controller reset, and a reset would also prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata[g] = mem[raddr[g]];
  end

endmodule

// File: rtl/layer_mem_ctrl.sv
// layer_mem_ctrl: layer-memory responder for the convolution engine.
// Holds the layer-0 (64x64) and layer-1 (32x32) maps, serves zero-latency
// reads and single-cycle writes, then streams layer 1 to the host once the
// engine finishes (busy falls).
//   clk, reset  clock, asynchronous active-high reset
//   busy        engine busy flag; a 1->0 sequence arms then starts readout
//   bus         engine bus + host stream (layer_mem_ctrl_if.slave)
//   done        one-cycle pulse after the last stream transfer
//   err         sticky protocol error (bad csel, out-of-range L1 write,
//               busy raised during readout); cleared only by reset
module layer_mem_ctrl
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              busy,
  layer_mem_ctrl_if.slave   bus,
  output logic              done,
  output logic              err
);

  // ---------------- csel decode / write steering ----------------
  logic sel_l0, sel_l1, sel_ok, l1_wr_in_range;
  logic wr_l0, wr_l1, err_set;

  assign sel_l0         = (bus.csel == SEL_L0);
  assign sel_l1         = (bus.csel == SEL_L1);
  assign sel_ok         = sel_l0 || sel_l1;
  assign l1_wr_in_range = (bus.caddr_wr[L0_AW-1:L1_AW] == '0);
  assign wr_l0          = bus.cwr && sel_l0;
  assign wr_l1          = bus.cwr && sel_l1 && l1_wr_in_range;

  // ---------------- banks ----------------
  rd_state_e                    state, state_nxt;
  logic [L1_AW-1:0]             ptr, stream_addr;
  logic                         out_valid_q, out_last_q, xfer, load;
  logic [DATA_W-1:0]            out_data_q;
  logic [0:0][DATA_W-1:0]       l0_rdata;
  logic [1:0][DATA_W-1:0]       l1_rdata;

  layer_bank #(.AW(L0_AW), .DATA_W(DATA_W), .NRD(1)) u_l0 (
    .clk   (clk),
    .we    (wr_l0),
    .waddr (bus.caddr_wr),
    .wdata (bus.cdata_wr),
    .raddr (bus.caddr_rd),
    .rdata (l0_rdata)
  );

  // Port 0 serves the engine, port 1 feeds the readout stream.
  layer_bank #(.AW(L1_AW), .DATA_W(DATA_W), .NRD(2)) u_l1 (
    .clk   (clk),
    .we    (wr_l1),
    .waddr (bus.caddr_wr[L1_AW-1:0]),
    .wdata (bus.cdata_wr),
    .raddr ({stream_addr, bus.caddr_rd[L1_AW-1:0]}),
    .rdata (l1_rdata)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    bus.cdata_rd = '0;
    if (bus.crd) begin
      if (sel_l0)      bus.cdata_rd = l0_rdata[0];
      else if (sel_l1) bus.cdata_rd = l1_rdata[0];
    end
  end

  // ---------------- readout FSM ----------------
  assign xfer = out_valid_q && bus.out_ready;
  // Before the first word is presented load ptr itself, afterwards the next one.
  assign stream_addr = out_valid_q ? ptr + 1'b1 : ptr;
  assign load = (state == ST_DRAIN) && (!out_valid_q || (xfer && !out_last_q));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (busy)  state_nxt = ST_ARMED;
      ST_ARMED: if (!busy) state_nxt = ST_DRAIN;
      ST_DRAIN: if (xfer && out_last_q) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (state == ST_ARMED && !busy) begin
      ptr         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      ptr         <= stream_addr;
      out_valid_q <= 1'b1;
      out_data_q  <= l1_rdata[1];
      out_last_q  <= (stream_addr == L1_LAST);
    end else if (state == ST_DRAIN && xfer) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = ptr;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign done          = (state == ST_DONE);

  // ---------------- sticky error ----------------
  assign err_set = (bus.cwr && !sel_ok) ||
                   (bus.cwr && sel_l1 && !l1_wr_in_range) ||
                   (bus.crd && !sel_ok) ||
                   (busy && state == ST_DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: tb/tb_layer_mem_ctrl.sv
// tb_layer_mem_ctrl: directed test of layer_mem_ctrl. Engine-side reads
// are compared directly; the host stream is checked by a scoreboard queue
// filled when a drain is started and emptied by an independent monitor.
module tb_layer_mem_ctrl;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic done, err;

  layer_mem_ctrl_if bus ();

  layer_mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .bus   (bus.slave),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L1_AW-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } xfer_t;

  xfer_t             sb_q[$];
  logic [DATA_W-1:0] l1_model [1024];
  int                checks = 0;
  int                errors = 0;
  int                xfer_cnt = 0;
  int                done_cnt = 0;
  bit                exp_done = 0;
  bit                prev_stall = 0;
  logic [L1_AW-1:0]  prev_addr;
  logic [DATA_W-1:0] prev_data;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stream monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_done   = 0;
      prev_stall = 0;
    end else begin
      if (exp_done || done) check("done_pulse", {31'b0, done}, {31'b0, exp_done});
      if (done) done_cnt++;
      exp_done = 0;
      if (prev_stall) begin
        check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        check("stall_addr", {22'b0, bus.out_addr}, {22'b0, prev_addr});
        check("stall_data", {12'b0, bus.out_data}, {12'b0, prev_data});
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got addr 0x%0h with empty scoreboard", bus.out_addr);
        end else begin
          xfer_t e;
          e = sb_q.pop_front();
          check("xfer_addr", {22'b0, bus.out_addr}, {22'b0, e.addr});
          check("xfer_data", {12'b0, bus.out_data}, {12'b0, e.data});
          check("xfer_last", {31'b0, bus.out_last}, {31'b0, e.last});
          if (e.last) exp_done = 1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_addr  = bus.out_addr;
      prev_data  = bus.out_data;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic eng_write(logic [2:0] sel, logic [11:0] addr, logic [19:0] data);
    bus.csel     = sel;
    bus.caddr_wr = addr;
    bus.cdata_wr = data;
    bus.cwr      = 1'b1;
    @(posedge clk); #1;
    bus.cwr      = 1'b0;
  endtask

  task automatic read_check(string name, logic [2:0] sel, logic [11:0] addr, logic [19:0] exp);
    bus.csel     = sel;
    bus.caddr_rd = addr;
    bus.crd      = 1'b1;
    @(negedge clk);
    check(name, {12'b0, bus.cdata_rd}, {12'b0, exp});
    @(posedge clk); #1;
    bus.crd      = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic start_drain();
    for (int i = 0; i < 1024; i++)
      sb_q.push_back('{addr: L1_AW'(i), data: l1_model[i], last: (i == 1023)});
    xfer_cnt = 0;
    busy = 1'b1;
    @(posedge clk); #1;
    busy = 1'b0;
  endtask

  task automatic wait_xfers(int n, string name);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (xfer_cnt < n && k < 3000);
    if (xfer_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, got %0d transfers expected %0d", name, xfer_cnt, n);
    end
  endtask

  initial begin
    logic [3:0] ready_pat;
    int n;
    int c;
    int done_before;

    ready_pat     = 4'b1001;
    reset         = 1'b1;
    busy          = 1'b0;
    bus.csel      = 3'd0;
    bus.cwr       = 1'b0;
    bus.caddr_wr  = '0;
    bus.cdata_wr  = '0;
    bus.crd       = 1'b0;
    bus.caddr_rd  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_cdata_rd", {12'b0, bus.cdata_rd}, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_addr", {22'b0, bus.out_addr}, 32'd0);
    check("rst_out_data", {12'b0, bus.out_data}, 32'd0);
    check("rst_out_last", {31'b0, bus.out_last}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Layer-0 write then read; crd=0 returns 0
    eng_write(SEL_L0, 12'h041, 20'h12345);
    read_check("l0_read", SEL_L0, 12'h041, 20'h12345);
    @(negedge clk);
    check("crd0_zero", {12'b0, bus.cdata_rd}, 32'd0);
    @(posedge clk); #1;

    // Fill layer 1 with a known pattern plus the hand-picked words
    for (int i = 0; i < 1024; i++) begin
      l1_model[i] = 20'(i * 1237 + 165);
      eng_write(SEL_L1, 12'(i), l1_model[i]);
    end
    l1_model[1023] = 20'hFFFFF; eng_write(SEL_L1, 12'h3FF, 20'hFFFFF);
    l1_model[0]    = 20'h00001; eng_write(SEL_L1, 12'h000, 20'h00001);
    l1_model[5]    = 20'h00007; eng_write(SEL_L1, 12'h005, 20'h00007);

    // Same-cycle write and read of L1 addr 5: old word now, new word next
    bus.csel     = SEL_L1;
    bus.caddr_wr = 12'h005;
    bus.cdata_wr = 20'h00009;
    bus.caddr_rd = 12'h005;
    bus.cwr      = 1'b1;
    bus.crd      = 1'b1;
    @(negedge clk);
    check("rw_same_old", {12'b0, bus.cdata_rd}, 32'h00007);
    @(posedge clk); #1;
    bus.cwr = 1'b0;
    @(negedge clk);
    check("rw_same_new", {12'b0, bus.cdata_rd}, 32'h00009);
    check("rw_same_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    bus.crd = 1'b0;
    l1_model[5] = 20'h00009;

    // Drain 1: ready held high; done 1027 negedges after busy drops
    bus.out_ready = 1'b1;
    start_drain();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 1200);
    check("drain1_latency", n, 32'd1027);
    check("drain1_sb_empty", sb_q.size(), 32'd0);
    check("drain1_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;

    // Drain 2: ready pattern 1,0,0,1 repeating
    done_before = done_cnt;
    start_drain();
    c = 0;
    while (done_cnt == done_before && c < 6000) begin
      bus.out_ready = ready_pat[c % 4];
      @(posedge clk); #1;
      c++;
    end
    bus.out_ready = 1'b1;
    check("drain2_done_cnt", done_cnt, done_before + 1);
    check("drain2_sb_empty", sb_q.size(), 32'd0);
    check("drain2_xfers", xfer_cnt, 32'd1024);

    // Invalid csel write: dropped, err set
    eng_write(3'd2, 12'h041, 20'h55555);
    @(negedge clk);
    check("bad_csel_err", {31'b0, err}, 32'd1);
    @(posedge clk); #1;
    read_check("bad_csel_l0", SEL_L0, 12'h041, 20'h12345);
    read_check("bad_csel_l1", SEL_L1, 12'h041, l1_model[12'h041]);
    pulse_reset();
    @(negedge clk);
    check("err_cleared", {31'b0, err}, 32'd0);
    @(posedge clk); #1;

    // Out-of-range L1 write: dropped, err set and sticky
    eng_write(SEL_L1, 12'h400, 20'h2AAAA);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("l1_range_err", {31'b0, err}, 32'd1);
    @(posedge clk); #1;
    read_check("l1_range_nowrite", SEL_L1, 12'h000, 20'h00001);
    pulse_reset();

    // Drain 3: busy raised mid-drain, then reset at transfer 500
    bus.out_ready = 1'b1;
    start_drain();
    wait_xfers(100, "drain3_100");
    #1;
    busy = 1'b1;
    @(posedge clk); #1;
    busy = 1'b0;
    @(negedge clk);
    check("busy_in_drain_err", {31'b0, err}, 32'd1);
    wait_xfers(500, "drain3_500");
    #1;
    done_before = done_cnt;
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_addr", {22'b0, bus.out_addr}, 32'd0);
    check("midrst_data", {12'b0, bus.out_data}, 32'd0);
    check("midrst_last", {31'b0, bus.out_last}, 32'd0);
    @(posedge clk); #1;
    sb_q.delete();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, done_before);
    check("midrst_err", {31'b0, err}, 32'd0);
    read_check("midrst_l0", SEL_L0, 12'h041, 20'h12345);
    read_check("midrst_l1_0", SEL_L1, 12'h000, 20'h00001);
    read_check("midrst_l1_5", SEL_L1, 12'h005, 20'h00009);
    read_check("midrst_l1_last", SEL_L1, 12'h3FF, 20'hFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
